iomem_gpio: RTL and testbench

Memory-mapped GPIO peripheral on the SoC `iomem_*` bus, used for the KV260 PMOD/LED pins. It provides per-pin direction and output data, two-flop-synchronised input sampling, and per-pin edge-detect interrupts. The combined interrupt drives CPU `irq_5`. The block answers only inside its own 256-byte window. Outside that window it returns ready=0 and rdata=0, so its bus outputs can be OR-merged with other iomem slaves.

---
 rtl/iomem_gpio_pkg.sv | 27 ++
 rtl/iomem_gpio_sync.sv | 26 ++
 rtl/iomem_gpio.sv | 127 ++++++++++++
 tb/tb_iomem_gpio.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_gpio_pkg.sv
// Shared definitions for the iomem GPIO peripheral: register map, window
// decode width, bus FSM states and byte-strobe helpers.
package iomem_gpio_pkg;

  localparam int         DECODE_W     = 8;
  localparam logic [7:0] OFF_DATA_OUT = 8'h00;
  localparam logic [7:0] OFF_DIR      = 8'h04;
  localparam logic [7:0] OFF_DATA_IN  = 8'h08;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
  localparam logic [7:0] OFF_EDGE_SEL = 8'h10;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h14;

  typedef enum logic {ST_IDLE, ST_ACK} bus_state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

  function automatic logic [31:0] merge_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] m;
    m = byte_mask(wstrb);
    return (cur & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/iomem_gpio_sync.sv
// Two-flop synchroniser for asynchronous GPIO pin inputs.
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
    end
  end

  assign o_q = r_sync2;

endmodule

// File: rtl/iomem_gpio.sv
// Memory-mapped GPIO on the iomem bus: direction/output registers, synchronised
// inputs and per-pin edge interrupts; bus outputs are zero outside the window.
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  input  logic [3:0]       iomem_wstrb,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  bus_state_t       r_state;
  logic             r_ready;
  logic [31:0]      r_rdata;
  logic [WIDTH-1:0] r_out, r_dir, r_en, r_esel, r_stat, r_prev;

  logic [WIDTH-1:0] w_din, w_edge, w_set, w_clr;
  logic [7:0]       w_off;
  logic             w_hit, w_sel, w_wr;
  logic [31:0]      w_cur, w_merge, w_clr32;
  logic             w_unused;

  function automatic logic [31:0] ext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (gpio_in),
    .o_q    (w_din)
  );

  assign w_off = {iomem_addr[7:2], 2'b00};
  assign w_hit = (iomem_addr[31:DECODE_W] == BASE_ADDR[31:DECODE_W]);
  assign w_sel = iomem_valid && w_hit && !r_ready && (r_state == ST_IDLE);
  assign w_wr  = w_sel && (|iomem_wstrb);

  always_comb begin
    w_cur = '0;
    case (w_off)
      OFF_DATA_OUT: w_cur = ext(r_out);
      OFF_DIR:      w_cur = ext(r_dir);
      OFF_DATA_IN:  w_cur = ext(w_din);
      OFF_IRQ_EN:   w_cur = ext(r_en);
      OFF_EDGE_SEL: w_cur = ext(r_esel);
      OFF_IRQ_STAT: w_cur = ext(r_stat);
      default:      w_cur = '0;
    endcase
  end

  assign w_merge = merge_wstrb(w_cur, iomem_wdata, iomem_wstrb);
  assign w_clr32 = iomem_wdata & byte_mask(iomem_wstrb);
  assign w_clr   = (w_wr && (w_off == OFF_IRQ_STAT)) ? w_clr32[WIDTH-1:0] : '0;

  // Edge polarity per pin; a set in the same cycle as a W1C clear wins.
  assign w_edge = ((w_din & ~r_prev) & r_esel) | ((~w_din & r_prev) & ~r_esel);
  assign w_set  = w_edge & r_en;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_out   <= '0;
      r_dir   <= '0;
      r_en    <= '0;
      r_esel  <= '0;
      r_stat  <= '0;
      r_prev  <= '0;
    end else begin
      r_prev <= w_din;
      r_stat <= (r_stat & ~w_clr) | w_set;
      case (r_state)
        ST_IDLE: begin
          if (w_sel) begin
            r_ready <= 1'b1;
            r_rdata <= (|iomem_wstrb) ? 32'h0 : w_cur;
            r_state <= ST_ACK;
            if (w_wr) begin
              case (w_off)
                OFF_DATA_OUT: r_out  <= w_merge[WIDTH-1:0];
                OFF_DIR:      r_dir  <= w_merge[WIDTH-1:0];
                OFF_IRQ_EN:   r_en   <= w_merge[WIDTH-1:0];
                OFF_EDGE_SEL: r_esel <= w_merge[WIDTH-1:0];
                default: ;
              endcase
            end
          end
        end
        ST_ACK: begin
          r_ready <= 1'b0;
          r_rdata <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_rdata <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign gpio_out    = r_out;
  assign gpio_oe     = r_dir;
  assign irq         = |r_stat;

  assign w_unused = ^{iomem_addr[1:0], w_merge, w_clr32};

endmodule

// File: tb/tb_iomem_gpio.sv
// Directed, table-driven bench for iomem_gpio: register map, strobes, window
// decode, edge interrupts, W1C/set collision, back-to-back access and abort.
module tb_iomem_gpio;

  localparam int          W = 8;
  localparam logic [31:0] B = 32'h0300_0000;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         iomem_valid = 1'b0;
  logic         iomem_ready;
  logic [31:0]  iomem_addr = '0;
  logic [31:0]  iomem_wdata = '0;
  logic [3:0]   iomem_wstrb = '0;
  logic [31:0]  iomem_rdata;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  int n_vec = 0;
  int n_err = 0;

  iomem_gpio #(.WIDTH(W), .BASE_ADDR(B)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_wstrb (iomem_wstrb),
    .iomem_rdata (iomem_rdata),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that raised ready.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic ok);
    iomem_addr  = a;
    iomem_wdata = d;
    iomem_wstrb = s;
    iomem_valid = 1'b1;
    ok = 1'b0;
    rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) begin
        ok = 1'b1;
        rd = iomem_rdata;
        break;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic ok;
    bus(B | 32'(off), 32'h0, 4'h0, rd, ok);
    check({name, "_rdy"}, 32'(ok), 32'h1);
    check(name, rd, exp);
  endtask

  task automatic wr(input string name, input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic ok;
    bus(B | 32'(off), d, s, rd, ok);
    check({name, "_rdy"}, 32'(ok), 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        ok;
    logic [4:0]  pat;
    int          oow_bad;

    tbl[0]  = '{"rst_dout",  B | 32'h00, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[1]  = '{"rst_dir",   B | 32'h04, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[2]  = '{"rst_en",    B | 32'h0C, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[3]  = '{"rst_esel",  B | 32'h10, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[4]  = '{"rst_stat",  B | 32'h14, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[5]  = '{"w_dout_b0", B | 32'h00, 32'h0000_00A5, 4'h1, 1'b0, 32'h0};
    tbl[6]  = '{"w_dout_b1", B | 32'h00, 32'h0000_FF00, 4'h2, 1'b0, 32'h0};
    tbl[7]  = '{"dout_rd",   B | 32'h00, 32'h0,         4'h0, 1'b1, 32'h0000_00A5};
    tbl[8]  = '{"w_dir",     B | 32'h04, 32'h0000_F0F0, 4'hF, 1'b0, 32'h0};
    tbl[9]  = '{"dir_rd",    B | 32'h04, 32'h0,         4'h0, 1'b1, 32'h0000_00F0};
    tbl[10] = '{"w_dir_hi",  B | 32'h04, 32'h1234_5600, 4'hE, 1'b0, 32'h0};
    tbl[11] = '{"dir_keep",  B | 32'h04, 32'h0,         4'h0, 1'b1, 32'h0000_00F0};
    tbl[12] = '{"w_din",     B | 32'h08, 32'h0000_00FF, 4'hF, 1'b0, 32'h0};
    tbl[13] = '{"din_ro",    B | 32'h08, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[14] = '{"w_unmap",   B | 32'h1C, 32'h0000_00FF, 4'hF, 1'b0, 32'h0};
    tbl[15] = '{"unmap_rd",  B | 32'h1C, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[16] = '{"w_en",      B | 32'h0C, 32'h0000_01FF, 4'h3, 1'b0, 32'h0};
    tbl[17] = '{"en_rd",     B | 32'h0C, 32'h0,         4'h0, 1'b1, 32'h0000_00FF};
    tbl[18] = '{"w_esel",    B | 32'h10, 32'h0000_00AA, 4'hF, 1'b0, 32'h0};
    tbl[19] = '{"esel_rd",   B | 32'h10, 32'h0,         4'h0, 1'b1, 32'h0000_00AA};
    tbl[20] = '{"w_en0",     B | 32'h0C, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[21] = '{"w_esel0",   B | 32'h10, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[22] = '{"en0_rd",    B | 32'h0C, 32'h0,         4'h0, 1'b1, 32'h0};

    // Reset
    resetn = 1'b0;
    tick(3);
    check("rst_oe",    32'(gpio_oe),     32'h0);
    check("rst_irq",   32'(irq),         32'h0);
    check("rst_ready", 32'(iomem_ready), 32'h0);
    resetn = 1'b1;
    tick(1);

    for (int i = 0; i < 23; i++) begin
      bus(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, rd, ok);
      check({tbl[i].name, "_rdy"}, 32'(ok), 32'h1);
      if (tbl[i].chk) check(tbl[i].name, rd, tbl[i].exp);
    end
    check("tbl_gpio_out", 32'(gpio_out), 32'hA5);
    check("tbl_gpio_oe",  32'(gpio_oe),  32'hF0);

    // Output follows the register in the ready cycle
    bus(B, 32'h0000_003C, 4'h1, rd, ok);
    check("w3c_rdy", 32'(ok), 32'h1);
    check("gpio_out_n1", 32'(gpio_out), 32'h3C);

    // Out-of-window access is never acknowledged and drives zero
    tick(1);
    oow_bad = 0;
    iomem_addr  = 32'h0200_0004;
    iomem_wstrb = 4'h0;
    iomem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) oow_bad++;
    end
    iomem_valid = 1'b0;
    check("oow_silent", 32'(oow_bad), 32'h0);
    tick(1);

    // Rising edge on pin 0
    wr("w_en1",   8'h0C, 32'h01, 4'hF);
    wr("w_esel1", 8'h10, 32'h01, 4'hF);
    tick(2);
    gpio_in[0] = 1'b1;
    tick(1);
    check("irq_lat_e0", 32'(irq), 32'h0);
    tick(1);
    check("irq_lat_e1", 32'(irq), 32'h0);
    rd_chk("din_bit0", 8'h08, 32'h01);
    check("irq_lat_e2", 32'(irq), 32'h1);
    rd_chk("stat_rise", 8'h14, 32'h01);
    wr("w1c_bit0", 8'h14, 32'h01, 4'h1);
    check("irq_cleared", 32'(irq), 32'h0);
    rd_chk("stat_clr", 8'h14, 32'h00);

    // Masked toggle does not set status
    wr("w_en_off", 8'h0C, 32'h00, 4'hF);
    gpio_in[0] = 1'b0;
    tick(4);
    gpio_in[0] = 1'b1;
    tick(4);
    rd_chk("stat_masked", 8'h14, 32'h00);
    check("irq_masked", 32'(irq), 32'h0);

    // Falling-edge select on pin 3
    wr("w_en3", 8'h0C, 32'h08, 4'hF);
    gpio_in[3] = 1'b1;
    tick(4);
    rd_chk("stat_rise_ign", 8'h14, 32'h00);
    gpio_in[3] = 1'b0;
    tick(4);
    rd_chk("stat_fall", 8'h14, 32'h08);
    wr("w1c_bit3", 8'h14, 32'h08, 4'hF);
    rd_chk("stat_fall_clr", 8'h14, 32'h00);

    // Edge on pin 2 lands in the same cycle as its W1C
    wr("w_en2",   8'h0C, 32'h04, 4'hF);
    wr("w_esel5", 8'h10, 32'h05, 4'hF);
    gpio_in[2] = 1'b1;
    tick(4);
    rd_chk("stat_b2_pre", 8'h14, 32'h04);
    gpio_in[2] = 1'b0;
    tick(4);
    gpio_in[2] = 1'b1;
    tick(2);
    wr("w1c_race", 8'h14, 32'h04, 4'h1);
    rd_chk("stat_race", 8'h14, 32'h04);
    check("irq_race", 32'(irq), 32'h1);

    // Valid held across three reads
    tick(1);
    pat = '0;
    iomem_addr  = B;
    iomem_wstrb = 4'h0;
    iomem_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      pat[i] = iomem_ready;
      if (iomem_ready) check("b2b_data", iomem_rdata, 32'h3C);
    end
    iomem_valid = 1'b0;
    check("b2b_pattern", 32'(pat), 32'h15);
    tick(1);

    // Reset asserted in the access cycle
    iomem_addr  = B | 32'h04;
    iomem_wstrb = 4'h0;
    iomem_valid = 1'b1;
    resetn      = 1'b0;
    tick(1);
    check("abort_ready", 32'(iomem_ready), 32'h0);
    check("abort_rdata", iomem_rdata,      32'h0);
    check("abort_out",   32'(gpio_out),    32'h0);
    check("abort_oe",    32'(gpio_oe),     32'h0);
    check("abort_irq",   32'(irq),         32'h0);
    iomem_valid = 1'b0;
    tick(1);
    check("abort_ready2", 32'(iomem_ready), 32'h0);
    resetn = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
